// File: rtl/idex_pipe_skid.sv
// ID/EX pipeline register with valid/ready handshake, optional two-entry skid buffer,
// flush-driven bubble insertion and a saturating stall-cycle counter.
module idex_pipe_skid #(
    parameter int unsigned PCSIZE  = 32,
    parameter int unsigned REGSIZE = 32,
    parameter int unsigned SKID    = 1,
    parameter int unsigned CNTW    = 16
) (
    input  logic               clk,
    input  logic               r,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic [PCSIZE-1:0]  IDEX_pc_i,
    input  logic [4:0]         IDEX_rs1_i,
    input  logic [4:0]         IDEX_rs2_i,
    input  logic [4:0]         IDEX_rd_i,
    input  logic [PCSIZE-1:0]  IDEX_imm_sext_i,
    input  logic [REGSIZE-1:0] IDEX_read_data1_i,
    input  logic [REGSIZE-1:0] IDEX_read_data2_i,
    input  logic               IDEX_reg_write_i,
    input  logic               IDEX_mem_2_reg_i,
    input  logic               IDEX_mem_read_i,
    input  logic               IDEX_mem_write_i,
    input  logic               IDEX_alu_src_i,
    input  logic [6:0]         IDEX_op_code_i,
    input  logic [9:0]         IDEX_func_code_i,
    output logic [PCSIZE-1:0]  IDEX_pc_o,
    output logic [4:0]         IDEX_rs1_o,
    output logic [4:0]         IDEX_rs2_o,
    output logic [4:0]         IDEX_rd_o,
    output logic [PCSIZE-1:0]  IDEX_imm_sext_o,
    output logic [REGSIZE-1:0] IDEX_read_data1_o,
    output logic [REGSIZE-1:0] IDEX_read_data2_o,
    output logic               IDEX_reg_write_o,
    output logic               IDEX_mem_2_reg_o,
    output logic               IDEX_mem_read_o,
    output logic               IDEX_mem_write_o,
    output logic               IDEX_alu_src_o,
    output logic [6:0]         IDEX_op_code_o,
    output logic [9:0]         IDEX_func_code_o,
    output logic [CNTW-1:0]    stall_cnt
);

    typedef struct packed {
        logic [PCSIZE-1:0]  pc;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [PCSIZE-1:0]  imm_sext;
        logic [REGSIZE-1:0] read_data1;
        logic [REGSIZE-1:0] read_data2;
        logic               reg_write;
        logic               mem_2_reg;
        logic               mem_read;
        logic               mem_write;
        logic               alu_src;
        logic [6:0]         op_code;
        logic [9:0]         func_code;
    } payload_t;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    payload_t        in_p;
    payload_t        out_q, out_d;
    payload_t        skid_q, skid_d;
    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            accept;
    logic            out_load;

    assign in_p = '{
        pc:         IDEX_pc_i,
        rs1:        IDEX_rs1_i,
        rs2:        IDEX_rs2_i,
        rd:         IDEX_rd_i,
        imm_sext:   IDEX_imm_sext_i,
        read_data1: IDEX_read_data1_i,
        read_data2: IDEX_read_data2_i,
        reg_write:  IDEX_reg_write_i,
        mem_2_reg:  IDEX_mem_2_reg_i,
        mem_read:   IDEX_mem_read_i,
        mem_write:  IDEX_mem_write_i,
        alu_src:    IDEX_alu_src_i,
        op_code:    IDEX_op_code_i,
        func_code:  IDEX_func_code_i
    };

    // Registered ready cuts the backpressure path; without a skid entry ready must look through.
    generate
        if (SKID != 0) begin : g_rdy_reg
            assign in_ready = !skid_valid_q;
        end else begin : g_rdy_comb
            assign in_ready = !out_valid_q || out_ready;
        end
    endgenerate

    assign accept   = in_valid && in_ready && !flush;
    assign out_load = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        cnt_d        = cnt_q;

        if (out_valid_q && !out_ready && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNTW'(1);
        end

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_load) begin
            // Skid entry is older than any input, so it always drains first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_d       = in_p;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Only reachable with the skid enabled; without it accept implies out_load.
            skid_valid_d = 1'b1;
            skid_d       = in_p;
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign stall_cnt         = cnt_q;
    assign IDEX_pc_o         = out_q.pc;
    assign IDEX_rs1_o        = out_q.rs1;
    assign IDEX_rs2_o        = out_q.rs2;
    assign IDEX_rd_o         = out_q.rd;
    assign IDEX_imm_sext_o   = out_q.imm_sext;
    assign IDEX_read_data1_o = out_q.read_data1;
    assign IDEX_read_data2_o = out_q.read_data2;
    assign IDEX_mem_2_reg_o  = out_q.mem_2_reg;
    assign IDEX_alu_src_o    = out_q.alu_src;
    assign IDEX_op_code_o    = out_q.op_code;
    assign IDEX_func_code_o  = out_q.func_code;
    // Side-effecting controls are masked so a bubble can never write state downstream.
    assign IDEX_reg_write_o  = out_q.reg_write && out_valid_q;
    assign IDEX_mem_read_o   = out_q.mem_read  && out_valid_q;
    assign IDEX_mem_write_o  = out_q.mem_write && out_valid_q;

endmodule
